wb_stage: RTL and testbench

//  Write-back stage; consumes the MEM/WB pipeline register outputs.

---
 rtl/wb_stage.sv | 139 +++++++++++++
 tb/tb_wb_stage.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// Write-back stage: selects/extends register-file write data, owns HI/LO,
// executes SYSCALL display/halt and counts retired instructions.
module wb_stage #(
    parameter int PC_BITS   = 32,
    parameter int IR_BITS   = 32,
    parameter int DATA_BITS = 32,
    parameter int CNT_BITS  = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [PC_BITS-1:0]   PC_in,
    input  logic [IR_BITS-1:0]   IR_in,
    input  logic [DATA_BITS-1:0] alu_out,
    input  logic [DATA_BITS-1:0] alu_out2,
    input  logic [DATA_BITS-1:0] mem_out,
    input  logic [5:0]           write,
    input  logic                 RegWrite,
    input  logic                 MemToReg,
    input  logic                 Jal,
    input  logic [1:0]           ExtrWord,
    input  logic                 ExtrSigned,
    input  logic [1:0]           LHToReg,
    input  logic                 ToLH,
    input  logic                 Syscall,
    input  logic [DATA_BITS-1:0] v0,
    input  logic [DATA_BITS-1:0] a0,
    output logic                 reg_we,
    output logic [4:0]           reg_waddr,
    output logic [DATA_BITS-1:0] reg_wdata,
    output logic [DATA_BITS-1:0] hi_q,
    output logic [DATA_BITS-1:0] lo_q,
    output logic                 disp_valid,
    output logic [DATA_BITS-1:0] disp_data,
    output logic                 halted,
    output logic [CNT_BITS-1:0]  retired
);

    typedef enum logic {
        RUN,
        HALT
    } state_e;

    state_e               state_q, state_d;
    logic [DATA_BITS-1:0] hi_d, lo_d;
    logic [DATA_BITS-1:0] disp_data_q, disp_data_d;
    logic                 disp_valid_q, disp_valid_d;
    logic [CNT_BITS-1:0]  retired_q, retired_d;

    logic [7:0]           byte_sel;
    logic [15:0]          half_sel;
    logic [DATA_BITS-1:0] ext_data;
    logic                 running;

    assign running = (state_q == RUN);

    always_comb begin
        byte_sel = mem_out[7:0];
        unique case (alu_out[1:0])
            2'd0: byte_sel = mem_out[7:0];
            2'd1: byte_sel = mem_out[15:8];
            2'd2: byte_sel = mem_out[23:16];
            2'd3: byte_sel = mem_out[31:24];
        endcase
        half_sel = alu_out[1] ? mem_out[31:16] : mem_out[15:0];
        unique case (ExtrWord)
            2'b01: ext_data = {{(DATA_BITS-8){ExtrSigned & byte_sel[7]}},
                               byte_sel};
            2'b10: ext_data = {{(DATA_BITS-16){ExtrSigned & half_sel[15]}},
                               half_sel};
            default: ext_data = mem_out;
        endcase
    end

    // Also the WB forwarding source, so this path stays purely combinational.
    always_comb begin
        if (Jal)
            reg_wdata = DATA_BITS'(PC_in + PC_BITS'(4));
        else if (LHToReg == 2'b01)
            reg_wdata = lo_q;
        else if (LHToReg == 2'b10)
            reg_wdata = hi_q;
        else if (MemToReg)
            reg_wdata = ext_data;
        else
            reg_wdata = alu_out;
    end

    assign reg_waddr = write[4:0];
    assign reg_we    = RegWrite & running & (write[4:0] != 5'd0);

    always_comb begin
        state_d      = state_q;
        hi_d         = hi_q;
        lo_d         = lo_q;
        disp_data_d  = disp_data_q;
        disp_valid_d = 1'b0;
        retired_d    = retired_q;
        if (running) begin
            if (ToLH) begin
                lo_d = alu_out;
                hi_d = alu_out2;
            end
            if (IR_in != '0)
                retired_d = retired_q + 1'b1;
            if (Syscall) begin
                if (v0 == DATA_BITS'(10)) begin
                    state_d = HALT;
                end else begin
                    disp_data_d  = a0;
                    disp_valid_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= RUN;
            hi_q         <= '0;
            lo_q         <= '0;
            disp_data_q  <= '0;
            disp_valid_q <= 1'b0;
            retired_q    <= '0;
        end else begin
            state_q      <= state_d;
            hi_q         <= hi_d;
            lo_q         <= lo_d;
            disp_data_q  <= disp_data_d;
            disp_valid_q <= disp_valid_d;
            retired_q    <= retired_d;
        end
    end

    assign halted     = (state_q == HALT);
    assign disp_valid = disp_valid_q;
    assign disp_data  = disp_data_q;
    assign retired    = retired_q;

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: extension/select table plus
// HI/LO, SYSCALL, counter-wrap and async-reset sequences.
module tb_wb_stage;

    localparam int CB = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] PC_in, IR_in, alu_out, alu_out2, mem_out, v0, a0;
    logic [5:0]  write;
    logic        RegWrite, MemToReg, Jal, ExtrSigned, ToLH, Syscall;
    logic [1:0]  ExtrWord, LHToReg;
    logic        reg_we, disp_valid, halted;
    logic [4:0]  reg_waddr;
    logic [31:0] reg_wdata, hi_q, lo_q, disp_data;
    logic [CB-1:0] retired;

    int n_vec = 0;
    int n_bad = 0;

    wb_stage #(.CNT_BITS(CB)) dut (
        .clk(clk), .rst_n(rst_n), .PC_in(PC_in), .IR_in(IR_in),
        .alu_out(alu_out), .alu_out2(alu_out2), .mem_out(mem_out),
        .write(write), .RegWrite(RegWrite), .MemToReg(MemToReg),
        .Jal(Jal), .ExtrWord(ExtrWord), .ExtrSigned(ExtrSigned),
        .LHToReg(LHToReg), .ToLH(ToLH), .Syscall(Syscall),
        .v0(v0), .a0(a0), .reg_we(reg_we), .reg_waddr(reg_waddr),
        .reg_wdata(reg_wdata), .hi_q(hi_q), .lo_q(lo_q),
        .disp_valid(disp_valid), .disp_data(disp_data),
        .halted(halted), .retired(retired)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        jal;
        logic [31:0] pc;
        logic        m2r;
        logic [1:0]  ew;
        logic        sgn;
        logic [31:0] alu;
        logic [31:0] mem;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[10];

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        PC_in = 0; IR_in = 0; alu_out = 0; alu_out2 = 0; mem_out = 0;
        v0 = 0; a0 = 0; write = 0; RegWrite = 0; MemToReg = 0; Jal = 0;
        ExtrWord = 0; ExtrSigned = 0; LHToReg = 0; ToLH = 0; Syscall = 0;
    endtask

    initial begin
        tbl[0] = '{"byte2_s", 0, 0, 1, 2'b01, 1, 32'h2, 32'h8081F2F3, 32'hFFFFFF81};
        tbl[1] = '{"byte2_u", 0, 0, 1, 2'b01, 0, 32'h2, 32'h8081F2F3, 32'h00000081};
        tbl[2] = '{"half1_s", 0, 0, 1, 2'b10, 1, 32'h2, 32'h8081F2F3, 32'hFFFF8081};
        tbl[3] = '{"byte0_s", 0, 0, 1, 2'b01, 1, 32'h0, 32'h8081F2F3, 32'hFFFFFFF3};
        tbl[4] = '{"byte3_u", 0, 0, 1, 2'b01, 0, 32'h3, 32'h8081F2F3, 32'h00000080};
        tbl[5] = '{"half0_u", 0, 0, 1, 2'b10, 0, 32'h1, 32'h8081F2F3, 32'h0000F2F3};
        tbl[6] = '{"word11",  0, 0, 1, 2'b11, 1, 32'h1, 32'h8081F2F3, 32'h8081F2F3};
        tbl[7] = '{"word00",  0, 0, 1, 2'b00, 0, 32'h0, 32'h8081F2F3, 32'h8081F2F3};
        tbl[8] = '{"alu",     0, 0, 0, 2'b01, 1, 32'h12345678, 32'hFFFFFFFF, 32'h12345678};
        tbl[9] = '{"jal",     1, 32'h3000, 1, 2'b01, 1, 32'h2, 32'h8081F2F3, 32'h00003004};

        idle();
        rst_n = 1'b0;
        #12;
        check("rst_hi", hi_q, 0);
        check("rst_retired", 32'(retired), 0);
        check("rst_halted", 32'(halted), 0);
        rst_n = 1'b1;
        tick();

        foreach (tbl[i]) begin
            Jal = tbl[i].jal; PC_in = tbl[i].pc; MemToReg = tbl[i].m2r;
            ExtrWord = tbl[i].ew; ExtrSigned = tbl[i].sgn;
            alu_out = tbl[i].alu; mem_out = tbl[i].mem;
            #1;
            check(tbl[i].name, reg_wdata, tbl[i].exp);
        end
        idle();

        // HI/LO write then read-back through LHToReg
        ToLH = 1; alu_out = 32'h11; alu_out2 = 32'h22;
        #1;
        check("hi_pre_edge", hi_q, 0);
        tick();
        idle();
        check("lo_after", lo_q, 32'h11);
        LHToReg = 2'b10; RegWrite = 1; write = 6'd8;
        #1;
        check("mfhi_data", reg_wdata, 32'h22);
        check("mfhi_addr", 32'(reg_waddr), 8);
        check("mfhi_we", 32'(reg_we), 1);
        LHToReg = 2'b01; ToLH = 1; alu_out = 32'h99; alu_out2 = 32'h88;
        #1;
        check("mflo_nobypass", reg_wdata, 32'h11);
        tick();
        check("mflo_new", reg_wdata, 32'h99);
        Jal = 1; PC_in = 32'h100; ToLH = 0;
        #1;
        check("jal_over_lh", reg_wdata, 32'h104);
        idle();
        RegWrite = 1; write = 6'd0;
        #1;
        check("we_r0", 32'(reg_we), 0);
        write = 6'h28;
        #1;
        check("we_bit5", 32'(reg_we), 1);
        check("addr_bit5", 32'(reg_waddr), 8);
        idle();

        Syscall = 1; v0 = 1; a0 = 32'hCAFE;
        tick();
        idle();
        check("disp_valid1", 32'(disp_valid), 1);
        check("disp_data", disp_data, 32'hCAFE);
        tick();
        check("disp_valid0", 32'(disp_valid), 0);
        check("disp_keep", disp_data, 32'hCAFE);
        check("ret_zero", 32'(retired), 0);

        // 20 instructions with 3 bubbles interleaved
        for (int k = 0; k < 23; k++) begin
            IR_in = (k % 7 == 3) ? 32'h0 : 32'h20 + k;
            tick();
        end
        IR_in = 0;
        check("ret_wrap", 32'(retired), 4);

        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        tick();
        IR_in = 32'h1234; ToLH = 1; alu_out = 3; alu_out2 = 7;
        for (int k = 0; k < 5; k++) tick();
        idle();
        check("pre_rst_ret", 32'(retired), 5);
        check("pre_rst_hi", hi_q, 7);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_ret", 32'(retired), 0);
        check("async_hi", hi_q, 0);
        check("async_lo", lo_q, 0);
        check("async_disp", disp_data, 0);
        #3;
        rst_n = 1'b1;
        tick();

        Syscall = 1; v0 = 10; a0 = 32'h77; IR_in = 32'hC;
        tick();
        check("halted", 32'(halted), 1);
        check("halt_nodisp", 32'(disp_valid), 0);
        check("halt_counted", 32'(retired), 1);
        v0 = 1; ToLH = 1; alu_out = 32'h55; alu_out2 = 32'h66;
        RegWrite = 1; write = 6'd8;
        #1;
        check("halt_we", 32'(reg_we), 0);
        tick();
        tick();
        check("halt_hi", hi_q, 0);
        check("halt_ret", 32'(retired), 1);
        check("halt_disp", disp_data, 0);
        check("halt_dv", 32'(disp_valid), 0);
        check("halt_sticky", 32'(halted), 1);
        idle();

        rst_n = 1'b0;
        #2;
        check("rst_unhalt", 32'(halted), 0);
        rst_n = 1'b1;
        IR_in = 32'h5; ToLH = 1; alu_out2 = 32'hAB;
        tick();
        idle();
        check("post_rst_ret", 32'(retired), 1);
        check("post_rst_hi", hi_q, 32'hAB);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
